// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood builder: shifts three aligned row taps into column registers and
// emits one registered window per accepted interior pixel, with last-of-frame flag.
module window_3x3_gen #(
    parameter int WIDTH_P  = 8,
    parameter int LINE_W_P = 640,
    parameter int LINE_H_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   row0_i,
    input  logic [WIDTH_P-1:0]   row1_i,
    input  logic [WIDTH_P-1:0]   row2_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [9*WIDTH_P-1:0] window_o,
    output logic                 last_o
);

    localparam int XW = $clog2(LINE_W_P);
    localparam int YW = $clog2(LINE_H_P);
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W_P - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINE_H_P - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [WIDTH_P-1:0]   tap_q [3][3];
    logic [WIDTH_P-1:0]   tap_d [3][3];
    logic [WIDTH_P-1:0]   row_in [3];
    logic [9*WIDTH_P-1:0] win_d;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic                 accept;
    logic                 interior;
    logic                 frame_end;

    assign ready_o   = ~valid_o | ready_i;
    assign accept    = valid_i & ready_o;
    assign interior  = (x_q >= X_TWO) && (y_q >= Y_TWO);
    assign frame_end = (x_q == X_LAST) && (y_q == Y_LAST);

    assign row_in[0] = row0_i;
    assign row_in[1] = row1_i;
    assign row_in[2] = row2_i;

    // Post-shift tap contents; the output window is loaded from these so it includes the new column.
    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            tap_d[r][0] = tap_q[r][0];
            tap_d[r][1] = tap_q[r][1];
            tap_d[r][2] = tap_q[r][2];
            if (accept) begin
                tap_d[r][0] = tap_q[r][1];
                tap_d[r][1] = tap_q[r][2];
                tap_d[r][2] = row_in[r];
            end
            for (int c = 0; c < 3; c++) begin
                win_d[(3*r+c)*WIDTH_P +: WIDTH_P] = tap_d[r][c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_q[r][c] <= '0;
                end
            end
            x_q      <= '0;
            y_q      <= '0;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            window_o <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_q[r][c] <= tap_d[r][c];
                end
            end
            if (accept) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
                valid_o  <= interior;
                last_o   <= frame_end;
                window_o <= win_d;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x3 frame: streaming, backpressure,
// back-to-back frames, gapped input and asynchronous mid-frame reset.
module tb_window_3x3_gen;

    localparam int WIDTH = 8;
    localparam int LW    = 4;
    localparam int LH    = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] row0_i;
    logic [WIDTH-1:0] row1_i;
    logic [WIDTH-1:0] row2_i;
    logic             valid_o;
    logic             ready_i;
    logic [9*WIDTH-1:0] window_o;
    logic             last_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int win_cnt;
    int last_cnt;

    always #5 clk = ~clk;

    window_3x3_gen #(.WIDTH_P(WIDTH), .LINE_W_P(LW), .LINE_H_P(LH)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .row0_i  (row0_i),
        .row1_i  (row1_i),
        .row2_i  (row2_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .window_o(window_o),
        .last_o  (last_o)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input logic [9*WIDTH-1:0] obs,
                             input logic [9*WIDTH-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pixel (x,y) has value 10*y+x; window element (r,c) is pixel (x-2+c, y-2+r).
    function automatic logic [9*WIDTH-1:0] exp_window(input int x, input int y);
        logic [9*WIDTH-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*WIDTH +: WIDTH] = 8'(10*(y-2+r) + (x-2+c));
        return w;
    endfunction

    task automatic drive_pixel(input int x, input int y);
        valid_i = 1'b1;
        row0_i  = 8'(10*(y-2) + x);
        row1_i  = 8'(10*(y-1) + x);
        row2_i  = 8'(10*y + x);
    endtask

    task automatic accept_and_check(input string tag, input int x, input int y);
        bit exp_valid;
        exp_valid = (x >= 2) && (y >= 2);
        drive_pixel(x, y);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check_bit($sformatf("%s_valid_%0d_%0d", tag, x, y), valid_o, exp_valid);
        if (exp_valid) begin
            check_win($sformatf("%s_win_%0d_%0d", tag, x, y), window_o, exp_window(x, y));
            check_bit($sformatf("%s_last_%0d_%0d", tag, x, y), last_o,
                      (x == LW-1) && (y == LH-1));
        end
        if (valid_o) win_cnt++;
        if (valid_o && last_o) last_cnt++;
    endtask

    task automatic stream_frame(input string tag, input bit gapped);
        win_cnt  = 0;
        last_cnt = 0;
        for (int y = 0; y < LH; y++) begin
            for (int x = 0; x < LW; x++) begin
                if (gapped) begin
                    valid_i = 1'b0;
                    @(posedge clk);
                    #1;
                    check_bit($sformatf("%s_gap_%0d_%0d", tag, x, y), valid_o, 1'b0);
                end
                accept_and_check(tag, x, y);
            end
        end
        check_int({tag, "_wincnt"}, win_cnt, 2);
        check_int({tag, "_lastcnt"}, last_cnt, 1);
    endtask

    initial begin
        rstn    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        row0_i  = '0;
        row1_i  = '0;
        row2_i  = '0;
        #1;
        check_bit("rst_valid", valid_o, 1'b0);
        check_bit("rst_last", last_o, 1'b0);
        check_win("rst_window", window_o, '0);
        check_bit("rst_ready", ready_o, 1'b1);
        ready_i = 1'b0;
        #1;
        check_bit("rst_ready_idle", ready_o, 1'b1);
        ready_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        stream_frame("f1", 1'b0);

        // Second frame back-to-back, stalling the (2,2) window for three cycles.
        win_cnt  = 0;
        last_cnt = 0;
        for (int y = 0; y < LH; y++) begin
            for (int x = 0; x < LW; x++) begin
                if (x == 3 && y == 2) begin
                    drive_pixel(3, 2);
                    ready_i = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        #1;
                        check_bit($sformatf("stall_ready_%0d", k), ready_o, 1'b0);
                        @(posedge clk);
                        #1;
                        check_bit($sformatf("stall_valid_%0d", k), valid_o, 1'b1);
                        check_win($sformatf("stall_win_%0d", k), window_o, exp_window(2, 2));
                        check_bit($sformatf("stall_last_%0d", k), last_o, 1'b0);
                    end
                    ready_i = 1'b1;
                    #1;
                    check_bit("release_ready", ready_o, 1'b1);
                end
                accept_and_check("f2", x, y);
            end
        end
        check_int("f2_wincnt", win_cnt, 2);
        check_int("f2_lastcnt", last_cnt, 1);

        stream_frame("f3", 1'b0);
        stream_frame("gap", 1'b1);

        // Partial frame up to (3,1), then asynchronous reset between edges.
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < LW; x++)
                accept_and_check("pre", x, y);
        check_bit("pre_rst_window_loaded", (window_o != '0), 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_bit("async_valid", valid_o, 1'b0);
        check_bit("async_last", last_o, 1'b0);
        check_win("async_window", window_o, '0);
        check_bit("async_ready", ready_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        stream_frame("post", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Assembles a 3x3 pixel neighbourhood from three vertically aligned row taps and emits one window per accepted pixel once the window lies fully inside the frame. It sits directly downstream of the two cascaded `ramdelaybuffer` line delays, which supply rows y-1 and y-2. It feeds the Sobel gradient kernel through a valid/ready handshake. The block tracks raster position internally, suppresses border windows, and flags the last window of each frame.

## Interface
- `WIDTH_P`, default 8: pixel width in bits.
- `LINE_W_P`, default 640: pixels per line; must be ≥3.
- `LINE_H_P`, default 480: lines per frame; must be ≥3.

- `clk_i`, in, 1: single clock, rising edge.
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `valid_i`, in, 1: all three row taps are valid.
- `ready_o`, out, 1: the block can accept a column this cycle.
- `row0_i`, in, `WIDTH_P`: pixel at (x, y-2), from the second line delay.
- `row1_i`, in, `WIDTH_P`: pixel at (x, y-1), from the first line delay.
- `row2_i`, in, `WIDTH_P`: pixel at (x, y), the current stream.
- `valid_o`, out, 1: the window is valid.
- `ready_i`, in, 1: the downstream kernel accepts the window.
- `window_o`, out, `9*WIDTH_P`: the window. Pixel (r,c) is at `[(3*r+c)*WIDTH_P +: WIDTH_P]`.
  - r=0 is row y-2 (top); c=0 is column x-2 (left).
- `last_o`, out, 1: the window is centred at (W-2, H-2), i.e. the final window of the frame.

## Operation
- Accept a column when `valid_i & ready_o`.
  - Every other state update also happens only on accept, except the output handshake.
- Column shift registers: three rows × three taps.
  - On accept, each row shifts left: c0←c1, c1←c2, c2←input.
  - The registers are not cleared at line start; stale columns are masked by the border rule.
- Position counters: `x_q` has width `$clog2(LINE_W_P)`; `y_q` has width `$clog2(LINE_H_P)`.
  - `x_q` and `y_q` hold the coordinates of the next pixel to be accepted.
  - On accept, if `x_q==LINE_W_P-1`, then `x_q←0`, and `y_q` either increments or wraps to 0 when `y_q==LINE_H_P-1`. Otherwise `x_q` increments.
- Border rule: an accepted pixel at (x,y) produces a window only if x≥2 and y≥2.
  - This gives (W-2)×(H-2) windows per frame.
- Output register: `valid_o`, `window_o` and `last_o` are registered.
  - On accept: `valid_o ← (x_q≥2 && y_q≥2)`; `window_o` ← the post-shift register contents; `last_o ← (x_q==W-1 && y_q==H-1)`.
  - With no accept and `ready_i=1`, `valid_o←0`.
- Backpressure: `ready_o = ~valid_o | ready_i`, combinational.
  - A held window stays stable while `valid_o=1` and `ready_i=0`; no input is accepted during that time.
- A frame wraps seamlessly. The first window of the next frame appears only at (2,2), because y restarts at 0.

## Timing
- Reset values: `valid_o=0`, `last_o=0`, `window_o=0`, all shift taps 0, `x_q=0`, `y_q=0`.
  - After reset, `ready_o=1`.
- Latency: an accept in cycle N presents the window in cycle N+1.
- Full throughput: one window per cycle when `valid_i` and `ready_i` are held high.
- Simultaneous consume and accept in the same cycle: the output reloads with no bubble.
- Border accepts (x<2 or y<2) consume input but drive `valid_o` to 0 on the next cycle. If a valid window is still pending, the accept is blocked by `ready_o`.
- A reset assertion mid-frame immediately clears every output and counter. The next accepted pixel is treated as (0,0).
- `valid_i` dropping mid-line: no state changes and the position is preserved.

## Test plan
- Reset, `W=4`, `H=3`, pixel value = 10*y+x streamed with `ready_i=1`:
  - Exactly 2 windows appear, at the accepts of (2,2) and (3,2).
  - The (2,2) window: r0=[0,1,2], r1=[10,11,12], r2=[20,21,22].
  - `last_o=1` only on the (3,2) window.
- Same stream, `ready_i` low for 3 cycles while window (2,2) is pending:
  - `window_o` is stable, `ready_o=0`, and no counter advances.
  - After release, window (3,2) follows one cycle later.
- Two back-to-back frames:
  - The second frame produces no window before its (2,2).
  - The window count is 2 per frame, and `last_o` pulses once per frame.
- `valid_i` gapped every other cycle: the windows are identical to the gapless run, and `valid_o` pulses only after accepts.
- Assert `rstn_i` asynchronously at (3,1):
  - `valid_o`, `last_o` and `window_o` read 0 before the next clock edge.
  - A restarted frame's first window appears at its own (2,2).
- `W=640`, `H=480`, random `valid_i`/`ready_i`:
  - Scoreboard 638×478 windows against a reference model.
  - Check `last_o` on window index 304963 (0-based), the final one.
